// File: rtl/regfile_port_ctrl.sv
// Command sequencer for an 8x16 register file port: WRITE / READ / COPY / CLEAR
// commands come in over valid/ready, and one response goes out per command.
module regfile_port_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic [ADDR_W-1:0] rf_readnum,
  output logic              rf_write,
  input  logic [DATA_W-1:0] rf_data_out
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(NREGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_CPWR, S_CLR, S_RESP} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          op_reg;
  logic [ADDR_W-1:0]   dst_reg;
  logic [ADDR_W-1:0]   readnum_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [DATA_W-1:0]   hold_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic [ADDR_W:0]     clr_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (cmd_valid) state_next = S_EXEC;
      S_EXEC: begin
        case (op_reg)
          OP_COPY:  state_next = S_CPWR;
          OP_CLEAR: state_next = S_CLR;
          default:  state_next = S_RESP;
        endcase
      end
      S_CPWR: state_next = S_RESP;
      S_CLR:  if (clr_cnt_reg == CLR_LAST) state_next = S_RESP;
      S_RESP: if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // readnum only moves when a reading command is accepted, so it holds outside EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg       <= OP_WRITE;
      dst_reg      <= '0;
      readnum_reg  <= '0;
      data_reg     <= '0;
      hold_reg     <= '0;
      rsp_data_reg <= '0;
      clr_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            op_reg   <= cmd_op;
            dst_reg  <= cmd_dst;
            data_reg <= cmd_data;
            if (cmd_op == OP_READ || cmd_op == OP_COPY) readnum_reg <= cmd_src;
          end
        end
        S_EXEC: begin
          case (op_reg)
            OP_WRITE: rsp_data_reg <= data_reg;
            OP_READ:  rsp_data_reg <= rf_data_out;
            OP_COPY:  hold_reg     <= rf_data_out;
            default:  clr_cnt_reg  <= '0;
          endcase
        end
        S_CPWR: rsp_data_reg <= hold_reg;
        S_CLR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == CLR_LAST) rsp_data_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign rsp_valid  = (state_reg == S_RESP);
  assign rsp_data   = rsp_data_reg;
  assign rf_readnum = readnum_reg;

  always_comb begin
    rf_write    = 1'b0;
    rf_writenum = dst_reg;
    rf_data_in  = '0;
    case (state_reg)
      S_EXEC: begin
        if (op_reg == OP_WRITE) begin
          rf_write   = 1'b1;
          rf_data_in = data_reg;
        end
      end
      S_CPWR: begin
        rf_write   = 1'b1;
        rf_data_in = hold_reg;
      end
      S_CLR: begin
        rf_write    = 1'b1;
        rf_writenum = clr_cnt_reg[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl paired with a behavioural 8x16 register file;
// expected responses go into a scoreboard queue checked by a separate monitor.
module tb_regfile_port_ctrl;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_dst;
  logic [2:0]  cmd_src;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;
  logic [15:0] rf_data_in;
  logic [2:0]  rf_writenum;
  logic [2:0]  rf_readnum;
  logic        rf_write;
  logic [15:0] rf_data_out;

  regfile_port_ctrl #(.DATA_W(16), .ADDR_W(3), .NREGS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .rf_data_in(rf_data_in), .rf_writenum(rf_writenum),
    .rf_readnum(rf_readnum), .rf_write(rf_write), .rf_data_out(rf_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file: combinational read, write on rising edge
  logic [15:0] rf [8];
  assign rf_data_out = rf[rf_readnum];
  always @(posedge clk) if (rf_write) rf[rf_writenum] <= rf_data_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [15:0] data;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [2:0] wlog[$];
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) if (reset_n && rf_write) wlog.push_back(rf_writenum);

  // monitor: latency on first rsp_valid, data every cycle held, pop on handshake
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          if (!prev_valid) chk({sb[0].name, "_lat"}, 32'(cyc), 32'(sb[0].acc + sb[0].lat - 1));
          chk({sb[0].name, "_data"}, 32'(rsp_data), 32'(sb[0].data));
          if (rsp_ready) begin
            $display("rsp %s data=%h cycle=%0d", sb[0].name, rsp_data, cyc);
            void'(sb.pop_front());
          end
        end
      end
      prev_valid <= rsp_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] dst, input logic [2:0] src,
                      input logic [15:0] data, input logic [15:0] exp, input int lat,
                      input string name);
    int t;
    exp_t e;
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_data = data;
    cmd_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      chk({name, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    e.name = name; e.data = exp; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
    $display("cmd %s op=%0d dst=%0d src=%0d data=%h accepted cycle=%0d", name, op, dst, src, data, cyc);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [15:0] v;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dst = '0; cmd_src = '0;
    cmd_data = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rf_write", 32'(rf_write), 32'd0);
    chk("rst_rf_data_in", 32'(rf_data_in), 32'd0);
    chk("rst_rf_writenum", 32'(rf_writenum), 32'd0);
    chk("rst_rf_readnum", 32'(rf_readnum), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // write then read back
    send(OP_WRITE, 3'd1, 3'd0, 16'h0002, 16'h0002, 2, "t1_write"); wait_done();
    send(OP_READ,  3'd0, 3'd1, 16'h0000, 16'h0002, 2, "t1_read");  wait_done();

    // copy across registers
    send(OP_WRITE, 3'd2, 3'd0, 16'h8CFA, 16'h8CFA, 2, "t2_write"); wait_done();
    send(OP_COPY,  3'd5, 3'd2, 16'h0000, 16'h8CFA, 3, "t2_copy");  wait_done();
    send(OP_READ,  3'd0, 3'd5, 16'h0000, 16'h8CFA, 2, "t2_read5"); wait_done();
    send(OP_READ,  3'd0, 3'd2, 16'h0000, 16'h8CFA, 2, "t2_read2"); wait_done();

    // copy onto itself
    send(OP_WRITE, 3'd3, 3'd0, 16'hF080, 16'hF080, 2, "t6_write"); wait_done();
    send(OP_COPY,  3'd3, 3'd3, 16'h0000, 16'hF080, 3, "t6_copy");  wait_done();
    send(OP_READ,  3'd0, 3'd3, 16'h0000, 16'hF080, 2, "t6_read");  wait_done();

    // load all, clear, verify write sweep and contents
    for (int i = 0; i < 8; i++) begin
      v = 16'(16'h1111 * (i + 1));
      send(OP_WRITE, 3'(i), 3'd0, v, v, 2, "t3_load"); wait_done();
    end
    send(OP_CLEAR, 3'd0, 3'd0, 16'hFFFF, 16'h0000, 10, "t3_clear");
    wlog.delete();
    wait_done();
    chk("t3_clear_write_count", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < wlog.size()) chk("t3_clear_writenum", 32'(wlog[i]), 32'(i));
    for (int i = 0; i < 8; i++) begin
      send(OP_READ, 3'd0, 3'(i), 16'h0000, 16'h0000, 2, "t3_read0"); wait_done();
    end

    // response backpressure
    send(OP_WRITE, 3'd6, 3'd0, 16'h1234, 16'h1234, 2, "t4_write"); wait_done();
    rsp_ready = 1'b0;
    send(OP_READ, 3'd0, 3'd6, 16'h0000, 16'h1234, 2, "t4_read");
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("t4_hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done();
    chk("t4_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // reset in the middle of a clear sweep
    for (int i = 0; i < 8; i++) begin
      v = 16'(16'h1111 * (i + 1));
      send(OP_WRITE, 3'(i), 3'd0, v, v, 2, "t5_load"); wait_done();
    end
    send(OP_CLEAR, 3'd0, 3'd0, 16'h0000, 16'h0000, 10, "t5_clear");
    t = 0;
    @(negedge clk);
    while (!(rf_write && rf_writenum == 3'd3) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t5_reached_cnt3", 32'(rf_writenum), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_rf_write", 32'(rf_write), 32'd0);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    sb.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5_post_busy", 32'(busy), 32'd0);
    chk("t5_post_rsp_valid", 32'(rsp_valid), 32'd0);
    send(OP_READ, 3'd0, 3'd0, 16'h0000, 16'h0000, 2, "t5_read_r0"); wait_done();
    for (int i = 3; i < 8; i++) begin
      v = 16'(16'h1111 * (i + 1));
      send(OP_READ, 3'd0, 3'(i), 16'h0000, v, 2, "t5_read_kept"); wait_done();
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
